// File: rtl/cci_mpf_prim_byteena_wr_coalesce.sv
// Coalesces byte-enabled writes to one address into a single RAM port-0 write; optional stats via CCI_MPF_WR_COALESCE_STATS_EN.
// Latency: combinational pass-through on emit, held up to MAX_HOLD_CYCLES plus port-unavailable cycles.
// Backpressure: in_rdy drops only when a different address must wait for ram_port_avail.
module cci_mpf_prim_byteena_wr_coalesce #(
  parameter int N_ENTRIES       = 32,
  parameter int N_DATA_BITS     = 64,
  parameter int N_BYTE_BITS     = 8,
  parameter int MAX_HOLD_CYCLES = 4,
  localparam int AW = $clog2(N_ENTRIES),
  localparam int NB = N_DATA_BITS / N_BYTE_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_rdy,
  input  logic [AW-1:0]          in_addr,
  input  logic [NB-1:0]          in_byteena,
  input  logic [N_DATA_BITS-1:0] in_wdata,
  input  logic                   flush,
  input  logic                   ram_port_avail,
  output logic                   ram_wen,
  output logic [AW-1:0]          ram_addr,
  output logic [NB-1:0]          ram_byteena,
  output logic [N_DATA_BITS-1:0] ram_wdata,
`ifdef CCI_MPF_WR_COALESCE_STATS_EN
  output logic [31:0]            stat_ram_writes,
  output logic [31:0]            stat_merges,
`endif
  output logic                   idle
);

  localparam int AGEW = $clog2(MAX_HOLD_CYCLES + 1);
  localparam logic [AGEW-1:0] AGE_MAX = AGEW'(MAX_HOLD_CYCLES);

  if (MAX_HOLD_CYCLES < 1) begin : g_bad_hold
    $fatal(1, "MAX_HOLD_CYCLES must be >= 1");
  end

  logic                   hold_valid;
  logic [AW-1:0]          hold_addr;
  logic [NB-1:0]          hold_be;
  logic [N_DATA_BITS-1:0] hold_data;
  logic [AGEW-1:0]        age;

  logic                   match;
  logic                   accept;
  logic                   aged;
  logic                   emit;
  logic [NB-1:0]          merged_be;
  logic [N_DATA_BITS-1:0] merged_data;

  assign match  = hold_valid && (in_addr == hold_addr);
  assign in_rdy = !reset && (!hold_valid || match || ram_port_avail);
  assign accept = in_valid && in_rdy;
  assign aged   = (age == AGE_MAX);
  assign emit   = hold_valid && ram_port_avail && (flush || aged || (accept && !match));

  always_comb begin
    merged_data = hold_data;
    for (int b = 0; b < NB; b++) begin
      if (in_byteena[b])
        merged_data[b*N_BYTE_BITS +: N_BYTE_BITS] = in_wdata[b*N_BYTE_BITS +: N_BYTE_BITS];
    end
  end
  assign merged_be = hold_be | in_byteena;

  // A same-address write arriving on the emit cycle rides along in that write.
  assign ram_wen     = emit;
  assign ram_addr    = hold_addr;
  assign ram_byteena = (accept && match) ? merged_be : hold_be;
  assign ram_wdata   = (accept && match) ? merged_data : hold_data;
  assign idle        = !hold_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_addr  <= '0;
      hold_be    <= '0;
      hold_data  <= '0;
      age        <= '0;
    end else if (emit) begin
      age <= '0;
      if (accept && !match) begin
        hold_valid <= 1'b1;
        hold_addr  <= in_addr;
        hold_be    <= in_byteena;
        hold_data  <= in_wdata;
      end else begin
        hold_valid <= 1'b0;
        hold_addr  <= '0;
        hold_be    <= '0;
        hold_data  <= '0;
      end
    end else if (accept && !hold_valid) begin
      hold_valid <= 1'b1;
      hold_addr  <= in_addr;
      hold_be    <= in_byteena;
      hold_data  <= in_wdata;
      age        <= '0;
    end else begin
      // Merging does not restart the age, so the first write's latency stays bounded.
      if (accept) begin
        hold_be   <= merged_be;
        hold_data <= merged_data;
      end
      if (hold_valid && !aged)
        age <= age + AGEW'(1);
    end
  end

`ifdef CCI_MPF_WR_COALESCE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_ram_writes <= '0;
      stat_merges     <= '0;
    end else begin
      if (emit && (stat_ram_writes != 32'hFFFF_FFFF))
        stat_ram_writes <= stat_ram_writes + 32'd1;
      if (accept && match && (stat_merges != 32'hFFFF_FFFF))
        stat_merges <= stat_merges + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cci_mpf_prim_byteena_wr_coalesce.sv
// Directed bench for the write-coalescing stage: merge, age timeout, address change, backpressure, reset.
module tb_cci_mpf_prim_byteena_wr_coalesce;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_rdy;
  logic [4:0]  in_addr;
  logic [7:0]  in_byteena;
  logic [63:0] in_wdata;
  logic        flush;
  logic        ram_port_avail;
  logic        ram_wen;
  logic [4:0]  ram_addr;
  logic [7:0]  ram_byteena;
  logic [63:0] ram_wdata;
  logic        idle;
`ifdef CCI_MPF_WR_COALESCE_STATS_EN
  logic [31:0] stat_ram_writes;
  logic [31:0] stat_merges;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  cci_mpf_prim_byteena_wr_coalesce dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_rdy         (in_rdy),
    .in_addr        (in_addr),
    .in_byteena     (in_byteena),
    .in_wdata       (in_wdata),
    .flush          (flush),
    .ram_port_avail (ram_port_avail),
    .ram_wen        (ram_wen),
    .ram_addr       (ram_addr),
    .ram_byteena    (ram_byteena),
    .ram_wdata      (ram_wdata),
`ifdef CCI_MPF_WR_COALESCE_STATS_EN
    .stat_ram_writes(stat_ram_writes),
    .stat_merges    (stat_merges),
`endif
    .idle           (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [7:0] be, input logic [63:0] d);
    in_valid   = v;
    in_addr    = a;
    in_byteena = be;
    in_wdata   = d;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    ram_port_avail = 1'b1;
    drive(1'b0, 5'd0, 8'h00, 64'h0);
    #2;
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_wen", ram_wen, 0);
    chk("rst_idle", idle, 1);
    chk("rst_addr", ram_addr, 0);
    chk("rst_be", ram_byteena, 0);
    chk("rst_data", ram_wdata, 0);
    tick();
    reset = 1'b0;

    // T1 merge then flush
    tick();
    drive(1'b1, 5'd5, 8'h0F, 64'h1111_1111_1111_1111);
    #1;
    chk("t1_rdy0", in_rdy, 1);
    chk("t1_wen0", ram_wen, 0);
    tick();
    drive(1'b1, 5'd5, 8'hF0, 64'h2222_2222_2222_2222);
    #1;
    chk("t1_wen1", ram_wen, 0);
    chk("t1_rdy1", in_rdy, 1);
    tick();
    drive(1'b0, 5'd0, 8'h00, 64'h0);
    flush = 1'b1;
    #1;
    chk("t1_wen2", ram_wen, 1);
    chk("t1_addr", ram_addr, 5);
    chk("t1_be", ram_byteena, 8'hFF);
    chk("t1_data", ram_wdata, 64'h2222_2222_1111_1111);
    tick();
    flush = 1'b0;
    #1;
    chk("t1_idle", idle, 1);
    chk("t1_wen3", ram_wen, 0);

    // T2 age timeout
    drive(1'b1, 5'd3, 8'h01, 64'h0000_0000_0000_00AB);
    #1;
    chk("t2_rdy", in_rdy, 1);
    tick();
    drive(1'b0, 5'd0, 8'h00, 64'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t2_hold%0d", i), ram_wen, 0);
      tick();
    end
    #1;
    chk("t2_emit", ram_wen, 1);
    chk("t2_addr", ram_addr, 3);
    chk("t2_data", ram_wdata, 64'hAB);
    tick();
    #1;
    chk("t2_idle", idle, 1);
    chk("t2_wen_after", ram_wen, 0);

    // T3 address change back-to-back
    drive(1'b1, 5'd1, 8'h01, 64'hAAAA_AAAA_AAAA_AAAA);
    tick();
    drive(1'b1, 5'd2, 8'h80, 64'hBBBB_BBBB_BBBB_BBBB);
    #1;
    chk("t3_rdy", in_rdy, 1);
    chk("t3_wen", ram_wen, 1);
    chk("t3_addr", ram_addr, 1);
    chk("t3_be", ram_byteena, 8'h01);
    chk("t3_data", ram_wdata, 64'hAAAA_AAAA_AAAA_AAAA);
    tick();
    drive(1'b0, 5'd0, 8'h00, 64'h0);
    #1;
    chk("t3_held", idle, 0);
    chk("t3_wen_idle", ram_wen, 0);
    flush = 1'b1;
    #1;
    chk("t3_flush_wen", ram_wen, 1);
    chk("t3_flush_addr", ram_addr, 2);
    chk("t3_flush_be", ram_byteena, 8'h80);
    tick();
    flush = 1'b0;

    // T4 backpressure
    drive(1'b1, 5'd7, 8'h03, 64'h0000_0000_0000_7777);
    tick();
    ram_port_avail = 1'b0;
    drive(1'b1, 5'd8, 8'h0C, 64'h0000_0000_8888_0000);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("t4_rdy%0d", i), in_rdy, 0);
      chk($sformatf("t4_wen%0d", i), ram_wen, 0);
      tick();
    end
    ram_port_avail = 1'b1;
    #1;
    chk("t4_emit", ram_wen, 1);
    chk("t4_addr", ram_addr, 7);
    chk("t4_rdy", in_rdy, 1);
    tick();
    drive(1'b0, 5'd0, 8'h00, 64'h0);
    flush = 1'b1;
    #1;
    chk("t4_a8_wen", ram_wen, 1);
    chk("t4_a8_addr", ram_addr, 8);
    chk("t4_a8_be", ram_byteena, 8'h0C);
    tick();
    flush = 1'b0;

    // T5 age limit coincides with same-address input
    drive(1'b1, 5'd4, 8'h03, 64'h1111_1111_1111_1111);
    tick();
    drive(1'b0, 5'd0, 8'h00, 64'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t5_hold%0d", i), ram_wen, 0);
      tick();
    end
    drive(1'b1, 5'd4, 8'h0C, 64'h2222_2222_2222_2222);
    #1;
    chk("t5_wen", ram_wen, 1);
    chk("t5_rdy", in_rdy, 1);
    chk("t5_be", ram_byteena, 8'h0F);
    chk("t5_data", ram_wdata, 64'h1111_1111_2222_1111);
    tick();
    drive(1'b0, 5'd0, 8'h00, 64'h0);
    #1;
    chk("t5_idle", idle, 1);
    chk("t5_wen_after", ram_wen, 0);

    // T6 asynchronous reset mid-hold
    drive(1'b1, 5'd9, 8'hFF, 64'h9999_9999_9999_9999);
    tick();
    drive(1'b0, 5'd0, 8'h00, 64'h0);
    flush = 1'b1;
    #1;
    chk("t6_pre_wen", ram_wen, 1);
    chk("t6_pre_idle", idle, 0);
`ifdef CCI_MPF_WR_COALESCE_STATS_EN
    chk("t6_stat_writes", stat_ram_writes, 7);
    chk("t6_stat_merges", stat_merges, 2);
`endif
    #1;
    reset = 1'b1;
    #1;
    chk("t6_wen", ram_wen, 0);
    chk("t6_idle", idle, 1);
    chk("t6_rdy", in_rdy, 0);
`ifdef CCI_MPF_WR_COALESCE_STATS_EN
    chk("t6_stat_writes0", stat_ram_writes, 0);
    chk("t6_stat_merges0", stat_merges, 0);
`endif
    flush = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("t6_post_rdy", in_rdy, 1);
    chk("t6_post_idle", idle, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
